// File: rtl/i2s_pkg.sv
// i2s_pkg: shared sample width default and receiver FSM state encoding.
package i2s_pkg;
    localparam int I2S_AUDIO_DW = 16;
    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_state_e;
endpackage

// File: rtl/i2s_word_deser.sv
// i2s_word_deser: MSB-first word capture with a saturating bit counter.
// The word is zero-based on its first captured bit, so short words are zero-filled and long words truncated.
module i2s_word_deser
    import i2s_pkg::*;
#(
    parameter int DW = I2S_AUDIO_DW
) (
    input  logic          sclk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [DW-1:0] word
);
    localparam int CW = $clog2(DW + 1);
    localparam int IW = $clog2(DW);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] word_q, word_d;
    logic [IW-1:0] idx;
    assign idx = IW'(DW - 1 - int'(cnt_q));
    always_comb begin
        cnt_d  = clr ? '0 : cnt_q;
        word_d = word_q;
        if (!clr && en && cnt_q < CW'(DW)) begin
            word_d      = (cnt_q == '0) ? '0 : word_q;
            word_d[idx] = bit_in;
            cnt_d       = cnt_q + CW'(1);
        end
    end
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end
    // Next-state view lets the caller latch a word that completes on this very edge.
    assign word = word_d;
endmodule

// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser: I2S receiver that frames left/right words into stereo pairs
// and hands them out over a valid/ready handshake with a sticky overrun flag.
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW = I2S_AUDIO_DW
) (
    input  logic                sclk,
    input  logic                reset_n,
    input  logic                lrclk,
    input  logic                sdata,
    output logic [AUDIO_DW-1:0] left_rx_chan,
    output logic [AUDIO_DW-1:0] right_rx_chan,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    input  logic                overrun_clr
);
    i2s_state_e state_q, state_d;
    logic lrclk_q, rise, fall, frame_done, load;
    logic valid_q, valid_d, overrun_q, overrun_d;
    logic [AUDIO_DW-1:0] left_word, right_word, left_q, left_d, right_q, right_d;
    assign rise       = lrclk & ~lrclk_q;
    assign fall       = ~lrclk & lrclk_q;
    assign frame_done = (state_q == RIGHT) && fall;
    assign load       = frame_done && (!valid_q || sample_ready);
    i2s_word_deser #(.DW(AUDIO_DW)) u_left (
        .sclk(sclk), .reset_n(reset_n), .clr(fall), .en(state_q == LEFT),
        .bit_in(sdata), .word(left_word)
    );
    i2s_word_deser #(.DW(AUDIO_DW)) u_right (
        .sclk(sclk), .reset_n(reset_n), .clr(rise), .en(state_q == RIGHT),
        .bit_in(sdata), .word(right_word)
    );
    // Any edge the current state does not expect drops back to SYNC.
    always_comb begin
        state_d = state_q;
        if (fall)
            state_d = (state_q == LEFT) ? SYNC : LEFT;
        else if (rise)
            state_d = (state_q == LEFT) ? RIGHT : SYNC;
    end
    always_comb begin
        left_d    = load ? left_word : left_q;
        right_d   = load ? right_word : right_q;
        valid_d   = load || (valid_q && !sample_ready);
        overrun_d = (frame_done && valid_q && !sample_ready) || (overrun_q && !overrun_clr);
    end
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SYNC;
            lrclk_q   <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lrclk_q   <= lrclk;
            left_q    <= left_d;
            right_q   <= right_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end
    assign left_rx_chan  = left_q;
    assign right_rx_chan = right_q;
    assign sample_valid  = valid_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb_i2s_rx_deser: directed I2S stream with a queue scoreboard checked on each handshake.
module tb_i2s_rx_deser;
    localparam int DW = 16;
    logic sclk = 1'b0;
    logic reset_n, lrclk, sdata, sample_ready, overrun_clr, pend;
    logic [DW-1:0] left_rx_chan, right_rx_chan;
    logic sample_valid, overrun;
    logic [2*DW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    i2s_rx_deser #(.AUDIO_DW(DW)) dut (
        .sclk(sclk), .reset_n(reset_n), .lrclk(lrclk), .sdata(sdata),
        .left_rx_chan(left_rx_chan), .right_rx_chan(right_rx_chan),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One slot per bit; sdata lags lrclk by one slot, so a word's LSB rides the next word's first slot.
    task automatic send_word(input logic ch, input logic [DW-1:0] val, input int n, input int rdy = -1);
        for (int i = 0; i < n; i++) begin
            @(posedge sclk);
            #1;
            if (i == 0 && rdy >= 0) sample_ready = rdy[0];
            lrclk = ch;
            sdata = pend;
            pend  = val[n-1-i];
        end
    endtask

    always @(negedge sclk) begin
        if (reset_n && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pair: got %h/%h expected no pair", left_rx_chan, right_rx_chan);
            end else begin
                check("pair", {left_rx_chan, right_rx_chan}, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_n = 1'b1; lrclk = 1'b0; sdata = 1'b0; pend = 1'b0;
        sample_ready = 1'b1; overrun_clr = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        check("rst_left", left_rx_chan, 0);
        check("rst_right", right_rx_chan, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        // Stream starts mid-right-word; nothing may come out before a full pair.
        send_word(1'b1, 16'hFFFF, 7);
        send_word(1'b0, 16'h4567, 16);
        send_word(1'b1, 16'hCDEF, 16);
        check("startup_no_valid", sample_valid, 0);
        exp_q.push_back({16'h4567, 16'hCDEF});
        send_word(1'b0, 16'h0ABC, 12);
        send_word(1'b1, 16'h0123, 12);
        check("valid_dropped", sample_valid, 0);
        check("overrun_std", overrun, 0);
        exp_q.push_back({16'hABC0, 16'h1230});
        // Back-pressure: A held, B lost.
        send_word(1'b0, 16'h1111, 16);
        sample_ready = 1'b0;
        send_word(1'b1, 16'h2222, 16);
        exp_q.push_back({16'h1111, 16'h2222});
        send_word(1'b0, 16'h3333, 16);
        send_word(1'b1, 16'h4444, 16);
        send_word(1'b0, 16'h5555, 16);
        check("overrun_set", overrun, 1);
        check("held_valid", sample_valid, 1);
        check("held_pair", {left_rx_chan, right_rx_chan}, {16'h1111, 16'h2222});
        overrun_clr = 1'b1;
        send_word(1'b1, 16'h6666, 16);
        overrun_clr = 1'b0;
        check("overrun_clr", overrun, 0);
        exp_q.push_back({16'h5555, 16'h6666});
        // Accept A in the same cycle the 5555/6666 frame completes.
        send_word(1'b0, 16'h7777, 16, 1);
        check("overrun_simul", overrun, 0);
        send_word(1'b1, 16'h8888, 16);
        exp_q.push_back({16'h7777, 16'h8888});
        // Reset during left bit 7.
        send_word(1'b0, 16'hAAAA, 8);
        reset_n = 1'b0;
        #1;
        check("mid_rst_left", left_rx_chan, 0);
        check("mid_rst_right", right_rx_chan, 0);
        check("mid_rst_valid", sample_valid, 0);
        check("mid_rst_overrun", overrun, 0);
        send_word(1'b0, 16'h5A5A, 2);
        reset_n = 1'b1;
        send_word(1'b0, 16'h00FF, 6);
        send_word(1'b1, 16'h9999, 16);
        send_word(1'b0, 16'hFAFA, 16);
        send_word(1'b1, 16'h0F0F, 16);
        exp_q.push_back({16'hFAFA, 16'h0F0F});
        send_word(1'b0, 16'h0000, 16);
        repeat (4) @(posedge sclk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("overrun_final", overrun, 0);
        check("valid_final", sample_valid, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_rx_deser.md
I2S_RX_DESER -- requirements
Module: i2s_rx_deser

Interface
REQ-001 SHALL have parameter AUDIO_DW, default 16, audio sample width in bits.
REQ-002 SHALL have port sclk, input, 1, bit clock; sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port lrclk, input, 1, word select; 0 = left word, 1 = right word; changes one bit period before the MSB.
REQ-005 SHALL have port sdata, input, 1, serial data, MSB first.
REQ-006 SHALL have port left_rx_chan, output, AUDIO_DW, last complete left sample.
REQ-007 SHALL have port right_rx_chan, output, AUDIO_DW, last complete right sample.
REQ-008 SHALL have port sample_valid, output, 1, stereo pair available.
REQ-009 SHALL have port sample_ready, input, 1, consumer accepts the pair.
REQ-010 SHALL have port overrun, output, 1, sticky lost-frame flag.
REQ-011 SHALL have port overrun_clr, input, 1, clears overrun.

Function
REQ-012 SHALL register lrclk each cycle (lrclk_q); a word edge is lrclk != lrclk_q.
REQ-013 SHALL implement FSM states SYNC, LEFT, RIGHT.
REQ-014 SHALL leave SYNC only on a 1->0 word edge (to LEFT); all data before it is discarded.
REQ-015 SHALL move LEFT->RIGHT on a 0->1 edge and RIGHT->LEFT on a 1->0 edge.
REQ-016 SHALL treat the sdata bit sampled on an edge cycle as the last bit of the word just ending, and the bit in the following cycle as the MSB of the new word.
REQ-017 SHALL place word bit i (0 = MSB) at position AUDIO_DW-1-i via a saturating bit counter (0..AUDIO_DW).
REQ-018 SHALL zero-fill LSBs of words shorter than AUDIO_DW bits.
REQ-019 SHALL ignore bits beyond AUDIO_DW in longer words.
REQ-020 SHALL complete a frame at the RIGHT->LEFT edge; left_rx_chan, right_rx_chan and sample_valid update in the next cycle (1-cycle latency from edge).
REQ-021 SHALL hold left_rx_chan, right_rx_chan and sample_valid stable while sample_valid=1 and sample_ready=0.
REQ-022 SHALL deassert sample_valid the cycle after sample_valid && sample_ready, unless a new frame completes in that same cycle, in which case the new pair loads and sample_valid stays 1.
REQ-023 SHALL, when a frame completes while sample_valid=1 and sample_ready=0, drop the new frame, keep the held pair and set overrun.
REQ-024 SHALL clear overrun on overrun_clr=1; a simultaneous set takes priority (overrun stays 1).
REQ-025 SHALL return to SYNC if a word edge arrives in SYNC's wait for 1->0 mid-frame (e.g. 0->1 seen first); only the 1->0 edge leaves SYNC.

Reset
REQ-026 SHALL on reset_n=0 force state SYNC, bit counter 0, shift registers 0, lrclk_q 0, left_rx_chan 0, right_rx_chan 0, sample_valid 0, overrun 0.
REQ-027 SHALL, after reset release mid-frame, discard the partial frame and resynchronise per REQ-014.

Structure
REQ-028 SHALL take AUDIO_DW default and the FSM state enum from shared package i2s_pkg.
REQ-029 SHALL instantiate one sub-module i2s_word_deser (shift register plus saturating bit counter), used once per channel or once with channel steering.

Verification
REQ-030 Standard frames: left 16'h4567, right 16'hCDEF, sample_ready=1 -> sample_valid pulses 1 cycle after the 1->0 edge with those values; overrun stays 0.
REQ-031 Back-pressure: sample_ready=0 for two frames (A = 16'h1111/16'h2222, then B = 16'h3333/16'h4444) -> outputs hold A and overrun=1; overrun_clr -> overrun=0.
REQ-032 Short word: 12-bit words 12'hABC / 12'h123 -> left_rx_chan=16'hABC0, right_rx_chan=16'h1230.
REQ-033 Start-up: stream begins mid-right-word -> no sample_valid until one full LEFT+RIGHT pair after the first 1->0 edge.
REQ-034 Reset mid-frame: reset_n low for 2 cycles during LEFT bit 7 -> all outputs 0; next full frame 16'hFAFA/16'h0F0F received correctly.
REQ-035 Simultaneous accept and completion: sample_ready=1 in the cycle a new frame completes -> new pair loaded, sample_valid stays 1, overrun stays 0.
